// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared states, opcodes, ALU codes for the multicycle controller
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// rtl/multicycle_controller_aludec.sv - combinational ALU operation decoder
module aludec
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Unknown R-type functs fall back to add so the write-back still happens harmlessly
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle datapath
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done
);

    state_t     state;
    state_t     next_state;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_ADD;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state = S_FETCH;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
